// File: rtl/xbox_dmem_tcm_if.sv
// Bus bundle for the data TCM: core load/store port plus accelerator word port.
// The master side issues requests; the slave side is the TCM.
interface xbox_dmem_tcm_if #(
    parameter int AW = 12
) ();
    logic          xbox_dmem_rvalid;
    logic          xbox_dmem_wvalid;
    logic [18:0]   xbox_dmem_addr;
    logic [31:0]   xbox_dmem_wdata;
    logic [3:0]    xbox_dmem_wbe;
    logic          xbox_dmem_rready;
    logic [31:0]   xbox_dmem_rdata;
    logic          xbox_dmem_wready;

    logic          acc_req;
    logic          acc_we;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_gnt;
    logic          acc_rvalid;
    logic [31:0]   acc_rdata;

    modport master (
        output xbox_dmem_rvalid, xbox_dmem_wvalid, xbox_dmem_addr, xbox_dmem_wdata, xbox_dmem_wbe,
        input  xbox_dmem_rready, xbox_dmem_rdata, xbox_dmem_wready,
        output acc_req, acc_we, acc_addr, acc_wdata,
        input  acc_gnt, acc_rvalid, acc_rdata
    );

    modport slave (
        input  xbox_dmem_rvalid, xbox_dmem_wvalid, xbox_dmem_addr, xbox_dmem_wdata, xbox_dmem_wbe,
        output xbox_dmem_rready, xbox_dmem_rdata, xbox_dmem_wready,
        input  acc_req, acc_we, acc_addr, acc_wdata,
        output acc_gnt, acc_rvalid, acc_rdata
    );
endinterface

// File: rtl/xbox_dmem_tcm.sv
// Single-port data TCM shared by the core (byte-enabled, one-cycle response)
// and an accelerator (word access, same-cycle grant), with round-robin arbitration.
module xbox_dmem_tcm #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xbox_dmem_tcm_if.slave       bus,
    input  logic                 err_clr,
    output logic                 err_oor
);
    typedef enum logic {ST_IDLE, ST_RESP} core_st_e;

    localparam logic [16:0] DEPTH_W17 = 17'(DEPTH_WORDS);

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rd_data;
    core_st_e      r_state;
    logic          r_last_acc;
    logic          r_rready;
    logic          r_wready;
    logic          r_acc_rvalid;
    logic          r_err;

    logic          w_core_elig;
    logic          w_core_gnt;
    logic          w_acc_gnt;
    logic          w_is_wr;
    logic [16:0]   w_word;
    logic          w_oor;
    logic          w_ram_en;
    logic          w_ram_we;
    logic          w_ram_zero;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_ram_wdata;
    logic [3:0]    w_ram_be;
    logic          w_unused;

    assign w_unused = ^bus.xbox_dmem_addr[1:0];

    assign w_word  = bus.xbox_dmem_addr[18:2];
    assign w_oor   = (w_word >= DEPTH_W17);
    // A simultaneous read and write request is served as a write.
    assign w_is_wr = bus.xbox_dmem_wvalid;

    // Tie goes to whoever did not win last; nothing is granted while in reset.
    assign w_core_elig = (bus.xbox_dmem_rvalid | bus.xbox_dmem_wvalid) && (r_state == ST_IDLE);
    assign w_core_gnt  = rst_n && w_core_elig && (!bus.acc_req || r_last_acc);
    assign w_acc_gnt   = rst_n && bus.acc_req && !w_core_gnt;

    always_comb begin
        w_ram_en    = w_core_gnt | w_acc_gnt;
        w_ram_we    = 1'b0;
        w_ram_zero  = 1'b0;
        w_ram_idx   = bus.acc_addr;
        w_ram_wdata = bus.acc_wdata;
        w_ram_be    = 4'hF;
        if (w_core_gnt) begin
            w_ram_idx   = w_word[AW-1:0];
            w_ram_wdata = bus.xbox_dmem_wdata;
            w_ram_be    = bus.xbox_dmem_wbe;
            w_ram_we    = w_is_wr && !w_oor;
            w_ram_zero  = w_oor;
        end else if (w_acc_gnt) begin
            w_ram_we    = bus.acc_we;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_en) begin
            if (w_ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_ram_be[b]) r_mem[w_ram_idx][8*b +: 8] <= w_ram_wdata[8*b +: 8];
                end
            end else begin
                r_rd_data <= w_ram_zero ? 32'h0 : r_mem[w_ram_idx];
            end
        end
    end

    // Core FSM, response pulses, last-winner and sticky range error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_acc   <= 1'b1;
            r_rready     <= 1'b0;
            r_wready     <= 1'b0;
            r_acc_rvalid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_rready     <= w_core_gnt && !w_is_wr;
            r_wready     <= w_core_gnt && w_is_wr;
            r_acc_rvalid <= w_acc_gnt && !bus.acc_we;
            case (r_state)
                ST_IDLE: if (w_core_gnt) r_state <= ST_RESP;
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_core_gnt)     r_last_acc <= 1'b0;
            else if (w_acc_gnt) r_last_acc <= 1'b1;
            if (w_core_gnt && w_oor) r_err <= 1'b1;
            else if (err_clr)        r_err <= 1'b0;
        end
    end

    assign bus.acc_gnt          = w_acc_gnt;
    assign bus.xbox_dmem_rready = r_rready;
    assign bus.xbox_dmem_wready = r_wready;
    assign bus.xbox_dmem_rdata  = r_rready ? r_rd_data : 32'h0;
    assign bus.acc_rvalid       = r_acc_rvalid;
    assign bus.acc_rdata        = r_acc_rvalid ? r_rd_data : 32'h0;
    assign err_oor              = r_err;
endmodule

// File: tb/tb_xbox_dmem_tcm.sv
// Directed bench for xbox_dmem_tcm: stimulus pushes expected responses into a
// queue, a negedge monitor pops and compares whenever a response pulse appears.
module tb_xbox_dmem_tcm;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    typedef enum logic [1:0] {K_RD, K_WR, K_ACC} kind_e;
    typedef struct {
        kind_e       kind;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic err_oor;

    always #5 clk = ~clk;

    xbox_dmem_tcm_if #(.AW(AW)) bus();

    xbox_dmem_tcm #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .err_clr(err_clr),
        .err_oor(err_oor)
    );

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic void chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endfunction

    function automatic void push(input kind_e k, input logic [31:0] d);
        exp_t e;
        e.kind = k;
        e.data = d;
        sbq.push_back(e);
    endfunction

    // Monitor
    exp_t        m_e;
    kind_e       m_k;
    logic [31:0] m_d;
    int          m_nv;
    always @(negedge clk) begin
        m_nv = int'(bus.xbox_dmem_rready) + int'(bus.xbox_dmem_wready) + int'(bus.acc_rvalid);
        if (m_nv > 1) begin
            chk("one_resp_per_cycle", 32'(m_nv), 32'd1);
        end else if (m_nv == 1) begin
            m_k = bus.xbox_dmem_rready ? K_RD : (bus.xbox_dmem_wready ? K_WR : K_ACC);
            m_d = (m_k == K_ACC) ? bus.acc_rdata : bus.xbox_dmem_rdata;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got kind %0d data %h, expected no response", m_k, m_d);
            end else begin
                m_e = sbq.pop_front();
                chk("resp_kind", 32'(m_k), 32'(m_e.kind));
                chk("resp_data", m_d, m_e.data);
            end
        end
        if (!bus.xbox_dmem_rready) chk("core_rdata_zero_when_idle", bus.xbox_dmem_rdata, 32'h0);
        if (!bus.acc_rvalid)       chk("acc_rdata_zero_when_idle", bus.acc_rdata, 32'h0);
    end

    task automatic idle_bus();
        bus.xbox_dmem_rvalid = 1'b0;
        bus.xbox_dmem_wvalid = 1'b0;
        bus.xbox_dmem_addr   = '0;
        bus.xbox_dmem_wdata  = '0;
        bus.xbox_dmem_wbe    = '0;
        bus.acc_req          = 1'b0;
        bus.acc_we           = 1'b0;
        bus.acc_addr         = '0;
        bus.acc_wdata        = '0;
    endtask

    // Called just after a rising edge with the accelerator idle; grant is immediate.
    task automatic core_op(input string nm, input logic rv, input logic wv, input logic [18:0] a,
                           input logic [31:0] wd, input logic [3:0] be, input logic [31:0] exp_rd);
        bus.xbox_dmem_rvalid = rv;
        bus.xbox_dmem_wvalid = wv;
        bus.xbox_dmem_addr   = a;
        bus.xbox_dmem_wdata  = wd;
        bus.xbox_dmem_wbe    = be;
        if (wv) push(K_WR, 32'h0);
        else    push(K_RD, exp_rd);
        @(posedge clk); #1;
        bus.xbox_dmem_rvalid = 1'b0;
        bus.xbox_dmem_wvalid = 1'b0;
        @(negedge clk);
        chk1({nm, "_wready"}, bus.xbox_dmem_wready, wv);
        chk1({nm, "_rready"}, bus.xbox_dmem_rready, !wv);
        @(posedge clk); #1;
    endtask

    task automatic acc_op(input string nm, input logic we, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        bus.acc_req   = 1'b1;
        bus.acc_we    = we;
        bus.acc_addr  = a;
        bus.acc_wdata = wd;
        #1;
        chk1({nm, "_gnt"}, bus.acc_gnt, 1'b1);
        if (!we) push(K_ACC, exp_rd);
        @(posedge clk); #1;
        bus.acc_req = 1'b0;
        @(negedge clk);
        chk1({nm, "_rvalid"}, bus.acc_rvalid, !we);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        bus.acc_req = 1'b1;
        @(negedge clk);
        chk1("rst_acc_gnt", bus.acc_gnt, 1'b0);
        chk1("rst_rready", bus.xbox_dmem_rready, 1'b0);
        chk1("rst_wready", bus.xbox_dmem_wready, 1'b0);
        chk1("rst_acc_rvalid", bus.acc_rvalid, 1'b0);
        chk1("rst_err_oor", err_oor, 1'b0);
        chk("rst_rdata", bus.xbox_dmem_rdata, 32'h0);
        bus.acc_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Partial-word write over a zeroed word
        core_op("wr_zero",  1'b0, 1'b1, 19'h10, 32'h0000_0000, 4'hF, 32'h0);
        core_op("wr_be",    1'b0, 1'b1, 19'h10, 32'hA5A5_1234, 4'b0101, 32'h0);
        core_op("rd_be",    1'b1, 1'b0, 19'h10, 32'h0, 4'h0, 32'h00A5_0034);
        core_op("wr_nobe",  1'b0, 1'b1, 19'h10, 32'hFFFF_FFFF, 4'h0, 32'h0);
        core_op("rd_nobe",  1'b1, 1'b0, 19'h13, 32'h0, 4'h0, 32'h00A5_0034);

        // Accelerator write seen by the core
        acc_op("acc_wr5", 1'b1, 12'd5, 32'hCAFE_F00D, 32'h0);
        core_op("rd_w5",    1'b1, 1'b0, 19'h14, 32'h0, 4'h0, 32'hCAFE_F00D);

        // Read+write together is a write
        core_op("rw_both",  1'b1, 1'b1, 19'h0, 32'h0000_0001, 4'hF, 32'h0);
        core_op("rd_w0",    1'b1, 1'b0, 19'h0, 32'h0, 4'h0, 32'h0000_0001);
        acc_op("acc_rd0", 1'b0, 12'd0, 32'h0, 32'h0000_0001);

        // Out-of-range accesses
        chk1("err_before_oor", err_oor, 1'b0);
        core_op("rd_oor",   1'b1, 1'b0, 19'h7FFFC, 32'h0, 4'h0, 32'h0);
        chk1("err_after_oor_rd", err_oor, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk1("err_cleared", err_oor, 1'b0);
        core_op("wr_top",   1'b0, 1'b1, 19'h3FFC, 32'h1111_1111, 4'hF, 32'h0);
        core_op("wr_oor",   1'b0, 1'b1, 19'h7FFFC, 32'hDEAD_BEEF, 4'hF, 32'h0);
        chk1("err_after_oor_wr", err_oor, 1'b1);
        core_op("rd_top",   1'b1, 1'b0, 19'h3FFC, 32'h0, 4'h0, 32'h1111_1111);
        err_clr = 1'b1;
        @(posedge clk); #1;
        chk1("err_cleared2", err_oor, 1'b0);
        bus.xbox_dmem_rvalid = 1'b1;
        bus.xbox_dmem_addr   = 19'h40000;
        push(K_RD, 32'h0);
        @(posedge clk); #1;
        err_clr = 1'b0;
        bus.xbox_dmem_rvalid = 1'b0;
        chk1("err_set_beats_clr", err_oor, 1'b1);
        @(posedge clk); #1;

        // Round-robin with both requesters busy; an acc grant first makes the core win the tie
        acc_op("acc_rd5", 1'b0, 12'd5, 32'h0, 32'hCAFE_F00D);
        bus.xbox_dmem_rvalid = 1'b1;
        bus.xbox_dmem_addr   = 19'h14;
        bus.acc_req          = 1'b1;
        bus.acc_we           = 1'b0;
        bus.acc_addr         = 12'd0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) push(K_RD, 32'hCAFE_F00D);
            else            push(K_ACC, 32'h0000_0001);
            #1;
            chk1($sformatf("rr_acc_gnt%0d", k), bus.acc_gnt, k[0]);
            @(posedge clk); #1;
        end
        idle_bus();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset right after a core read grant drops the response
        bus.xbox_dmem_rvalid = 1'b1;
        bus.xbox_dmem_addr   = 19'h14;
        @(posedge clk); #1;
        bus.xbox_dmem_rvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk1("rst_mid_rready", bus.xbox_dmem_rready, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_rready", bus.xbox_dmem_rready, 1'b0);
        chk1("post_rst_err", err_oor, 1'b0);
        @(posedge clk); #1;
        core_op("rd_after_rst", 1'b1, 1'b0, 19'h0, 32'h0, 4'h0, 32'h0000_0001);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/xbox_dmem_tcm.md
XBOX_DMEM_TCM -- requirements
Module: xbox_dmem_tcm

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 4096, giving the number of 32-bit memory words (power of two, 256..32768).
REQ-002 The block SHALL have parameter AW, default $clog2(DEPTH_WORDS), giving the accelerator word-address width.
REQ-003 The block SHALL have port clk, input, 1, the single clock of the block (the system clock).
REQ-004 The block SHALL have port rst_n, input, 1, the reset: asynchronous assertion, active-low.
REQ-005 The block SHALL have port xbox_dmem_rvalid, input, 1, core read request, held high until the response.
REQ-006 The block SHALL have port xbox_dmem_wvalid, input, 1, core write request, held high until the response.
REQ-007 The block SHALL have port xbox_dmem_addr, input, 19, core byte address; bits [1:0] are ignored.
REQ-008 The block SHALL have port xbox_dmem_wdata, input, 32, core write data.
REQ-009 The block SHALL have port xbox_dmem_wbe, input, 4, core byte enables; bit i enables byte [8i+7:8i].
REQ-010 The block SHALL have port xbox_dmem_rready, output, 1, a single-cycle pulse marking core read data valid.
REQ-011 The block SHALL have port xbox_dmem_rdata, output, 32, core read data, valid only while rready=1.
REQ-012 The block SHALL have port xbox_dmem_wready, output, 1, a single-cycle pulse marking the core write as done.
REQ-013 The block SHALL have port acc_req, input, 1, accelerator access request.
REQ-014 The block SHALL have port acc_we, input, 1, accelerator write (1) or read (0); full-word access only.
REQ-015 The block SHALL have port acc_addr, input, AW, accelerator word address.
REQ-016 The block SHALL have port acc_wdata, input, 32, accelerator write data.
REQ-017 The block SHALL have port acc_gnt, output, 1, combinational same-cycle grant of acc_req.
REQ-018 The block SHALL have ports acc_rvalid (output, 1) and acc_rdata (output, 32), giving read data one cycle after grant.
REQ-019 The block SHALL have port err_oor, output, 1, a sticky flag for a core address outside the memory range.
REQ-020 The block SHALL have port err_clr, input, 1, which clears err_oor synchronously.

Function
REQ-021 The block SHALL contain single-port synchronous RAM, DEPTH_WORDS x 32, allowing one access per cycle.
REQ-022 In each cycle the arbiter SHALL grant at most one eligible requester: the core when (rvalid|wvalid) and core_state=IDLE, and the accelerator when acc_req=1.
REQ-023 When both requesters are eligible, the arbiter SHALL grant round-robin: the requester not granted last wins; the last-winner register resets to "acc", so the core wins the first tie.
REQ-024 The core-port FSM SHALL have states IDLE and RESP: a core grant in cycle N moves it to RESP; RESP returns to IDLE at cycle N+1; no core grant is possible in RESP.
REQ-025 For a core read granted at N: xbox_dmem_rready=1 and xbox_dmem_rdata=mem[addr[18:2]] SHALL appear at N+1.
REQ-026 For a core write granted at N: the enabled bytes SHALL be written at N and xbox_dmem_wready=1 SHALL appear at N+1; wbe=0 writes nothing but still pulses wready.
REQ-027 When rvalid and wvalid are both 1, the access SHALL be treated as a write and SHALL produce no rready.
REQ-028 When addr[18:2] >= DEPTH_WORDS: a write SHALL be dropped, a read SHALL return 32'h0, the response SHALL still pulse, and err_oor SHALL be set at N+1.
REQ-029 If err_clr and a new out-of-range response occur in the same cycle, err_oor SHALL be set (set has priority).
REQ-030 For an accelerator grant at N: a write SHALL update mem at N; a read SHALL give acc_rvalid=1 and acc_rdata at N+1.
REQ-031 Read-during-write is impossible (single port); a read after a write to the same word SHALL return the new data.
REQ-032 xbox_dmem_rdata and acc_rdata SHALL be 0 whenever their valid signal is 0.

Reset
REQ-033 While rst_n=0, all outputs SHALL be 0, core_state SHALL be IDLE, last-winner SHALL be "acc", and err_oor SHALL be 0.
REQ-034 Asserting rst_n mid-access SHALL discard the pending response with no pulse after release; RAM contents are not cleared.

Verification
REQ-035 Core write of 32'hA5A5_1234 to addr 0x10 with wbe=4'b0101, then read of 0x10 after a prior word of 0 -> wready at N+1, then rdata=32'h00A5_0034.
REQ-036 Core and accelerator request every cycle for 8 cycles -> grants alternate core/acc starting with the core, and core is never granted in RESP.
REQ-037 Core read of addr 19'h7FFFC with DEPTH_WORDS=4096 -> rready with rdata=0 and err_oor=1; err_clr pulse -> err_oor=0.
REQ-038 Accelerator writes 32'hCAFE_F00D to word 5, then core reads byte addr 0x14 -> rdata=32'hCAFE_F00D at one cycle after the core grant.
REQ-039 rvalid and wvalid both high with wdata=1 to addr 0 -> wready only, no rready, and mem[0]=1.
REQ-040 rst_n pulsed low in the cycle after a core read grant -> no rready after release, and the next core request is granted normally.
